// File: rtl/data_mem_unit_pkg.sv
// Shared encodings for the MEM-stage data-memory unit: access sizes and FSM states.
// No logic; imported by data_mem_unit and dm_be_gen.
// No flow control of its own.
package data_mem_unit_pkg;

    localparam logic [1:0] DM_W = 2'b00;
    localparam logic [1:0] DM_H = 2'b01;
    localparam logic [1:0] DM_B = 2'b10;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_DONE = 2'd2
    } dm_state_t;

endpackage

// File: rtl/data_mem_unit_be_gen.sv
// Byte-lane enable, store-data lane replication and misalignment detection.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs.
module dm_be_gen
    import data_mem_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misalign
);

    // Size 2'b11 falls through to the word defaults.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        misalign   = (addr_lo != 2'b00);
        case (size)
            DM_H: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
            end
            DM_B: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                misalign   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data memory: load/store on an internal word array after LATENCY wait cycles; optional DM_ALIGN_CHECK_EN rejects misaligned accesses.
// Latency LATENCY+1 cycles (1 cycle for a rejected access); done pulses in the completion cycle.
// Stalls the pipeline while a request is being accepted or in flight; requests are only sampled in IDLE.
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [1:0]  addr_lo,
    output logic        stall,
    output logic        done,
    output logic        exc
);

`ifdef DM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    dm_state_t                state, state_nxt;
    logic [3:0]               cnt;
    logic                     exc_q;
    logic                     we_q;
    logic [3:0]               be_q;
    logic [31:0]              wd_q;
    logic [ADDR_WIDTH-1:0]    idx_q;
    logic [1:0]               lo_q;
    logic [31:0]              mem [0:(1<<ADDR_WIDTH)-1];

    logic [3:0]               be;
    logic [31:0]              wd_lane;
    logic                     misalign;
    logic                     reject;
    logic                     accept;
    logic                     access;
    logic                     unused_addr_hi;

    // Upper address bits are dropped so accesses wrap modulo the array size.
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    dm_be_gen u_be_gen (
        .size       (size),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (be),
        .wdata_lane (wd_lane),
        .misalign   (misalign)
    );

    assign reject = ALIGN_CHK & misalign;
    assign accept = (state == DM_IDLE) && req;
    assign access = (state == DM_WAIT) && (cnt == 4'd0);
    assign stall  = accept || (state == DM_WAIT);
    assign done   = (state == DM_DONE);
    assign exc    = done & exc_q;

    always_comb begin
        state_nxt = state;
        case (state)
            DM_IDLE: if (req) state_nxt = reject ? DM_DONE : DM_WAIT;
            DM_WAIT: if (cnt == 4'd0) state_nxt = DM_DONE;
            DM_DONE: state_nxt = DM_IDLE;
            default: state_nxt = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DM_IDLE;
            cnt     <= 4'd0;
            exc_q   <= 1'b0;
            rdata   <= 32'd0;
            addr_lo <= 2'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt   <= 4'(LATENCY - 1);
                exc_q <= reject;
                if (reject) addr_lo <= addr[1:0];
            end else if ((state == DM_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                addr_lo <= lo_q;
                if (!we_q) rdata <= mem[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q  <= we;
            be_q  <= be;
            wd_q  <= wd_lane;
            idx_q <= addr[ADDR_WIDTH+1:2];
            lo_q  <= addr[1:0];
        end
    end

    // Array is never reset; a reset in the access cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && access && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Multi-cycle data-memory unit for the MEM stage. It takes a load/store request from the EX/MEM register and generates byte-lane enables for SW/SH/SB. It performs the access on an internal word array after a configurable latency, stalls the pipeline while the access is in flight, and presents the raw 32-bit word plus the address low bits to the load extender downstream.

## Interface
- ADDR_WIDTH, 10, word-address width; the array holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 1, wait cycles before the array access; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: `DM_W (00) word, `DM_H (01) half, `DM_B (10) byte; 11 is treated as word.
- addr  in  32  byte address (ALUOut).
- wdata  in  32  store data, right-aligned (rt value).
- rdata  out  32  raw word read; reset 0; held until the next load completes.
- addr_lo  out  2  addr[1:0] of the completed access; reset 0; feeds the load extender's byte select.
- stall  out  1  combinational: (IDLE & req) | WAIT; reset-state value 0 when req is 0.
- done  out  1  one-cycle completion pulse; reset 0.
- exc  out  1  misalignment flag, valid with done; reset 0.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE, req=1:**
  - Latch we, size, addr, wdata and the byte enables; load cnt = LATENCY-1.
  - Go to WAIT, or to DONE with exc=1 if misaligned (see Configuration).
- **WAIT, cnt≠0:** cnt decrements.
- **WAIT, cnt=0:** perform the access and go to DONE.
  - Store: write the byte lanes enabled in be; other lanes keep their value.
  - Load: rdata ← mem[addr[ADDR_WIDTH+1:2]].
- **DONE:** done=1 for one cycle, then return to IDLE unconditionally. A req present during DONE is not accepted; it is accepted next cycle in IDLE.
- **Byte enables and lane placement:**
  - Word: be=1111, data unchanged.
  - Half: be=0011 with addr[1]=0, 1100 with addr[1]=1; wdata[15:0] replicated to both halves.
  - Byte: be=0001<<addr[1:0]; wdata[7:0] replicated to all four lanes.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo the array size.
- Loads always read the full word; sign or zero extension is done downstream.
- A store does not change rdata. addr_lo updates on every completion.

## Timing
- req accepted at cycle 0; array access at cycle LATENCY; done at cycle LATENCY+1.
- Total latency is LATENCY+1 cycles.
- stall is high for cycles 0..LATENCY and low in the done cycle, so the pipeline advances in that cycle.
- Misaligned access: done and exc are asserted at cycle 1; stall is high only in cycle 0.
- A load following a store to the same word sees the stored data, because the write commits before the load's request is accepted.
- Reset during WAIT: a pending write is discarded and the FSM returns to IDLE. done, exc, rdata and addr_lo return to 0. Array contents are not cleared.

## Configuration
- `DM_ALIGN_CHECK_EN` defined:
  - A word access with addr[1:0]≠00 is rejected with exc=1.
  - A half access with addr[0]=1 is rejected with exc=1.
  - A rejected request skips WAIT and never touches the array.
  - we distinguishes AdES from AdEL for the exception handler.
- Undefined: exc is tied to 0.
  - A word access ignores addr[1:0].
  - A half access ignores addr[0].

## Structure
- Add `DM_W`, `DM_H`, `DM_B` and the state encodings `DM_IDLE`, `DM_WAIT`, `DM_DONE` to the shared public.v include.
- One sub-module: dm_be_gen (combinational).
  - Inputs: size, addr[1:0].
  - Outputs: be[3:0], lane-replicated write data and the misalign flag.
- The FSM, counter and array stay in the top module.

## Test plan
- Reset, then SW 0x12345678 to 0x10, then LW 0x10 (LATENCY=1): done two cycles after each req; rdata=0x12345678; stall high for exactly 2 cycles per access.
- SB 0xAB to 0x13, then LW 0x10: rdata=0xAB345678, addr_lo=00. SH 0xBEEF to 0x10, then LW 0x10: rdata=0xAB34BEEF.
- LATENCY=4, LW: done 5 cycles after req; req held during DONE is accepted exactly once, in the following IDLE cycle.
- `DM_ALIGN_CHECK_EN` on, SW to 0x11: exc=1 and done=1 at cycle 1; a later LW 0x10 shows unchanged data. Macro off: the same SW writes word 0x10.
- Assert rst during WAIT of SW 0xFFFFFFFF to 0x20: done never pulses; rdata=0; a later LW 0x20 returns the old value.
- SW to 0x1000 + 4·2^ADDR_WIDTH, then LW 0x1000: the same word is read back (wrap).
